// File: rtl/regfile_wen_sequencer_pkg.sv
// Shared decode definitions for the register-file write-enable path.
// Holds the sequencer state encoding and a generic binary-to-one-hot helper.
package cpu_decode_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    localparam int MAX_SEL_W = 8;
    localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

    // Widest supported strobe; callers keep the low 2**SEL_W bits.
    function automatic logic [MAX_OUT_W-1:0] onehot(input logic [MAX_SEL_W-1:0] sel);
        return MAX_OUT_W'(1) << sel;
    endfunction

endpackage

// File: rtl/regfile_wen_sequencer_if.sv
// Control-unit <-> write-enable sequencer bus.
// The master drives write/clear requests; the slave returns strobes and status.
interface regfile_wen_sequencer_if #(
    parameter int SEL_W = 4
);
    localparam int OUT_W = 2 ** SEL_W;

    logic             wr_en;
    logic [SEL_W-1:0] wr_sel;
    logic             clr_req;
    logic [OUT_W-1:0] dec_out;
    logic [SEL_W-1:0] clr_sel;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output wr_en, wr_sel, clr_req,
        input  dec_out, clr_sel, busy, done, err
    );

    modport slave (
        input  wr_en, wr_sel, clr_req,
        output dec_out, clr_sel, busy, done, err
    );

endinterface

// File: rtl/regfile_wen_sequencer_decoder.sv
// Purely combinational binary-to-one-hot decoder; every select value maps
// to exactly one set bit, so the output is never X for a known select.
module decoder_n_to_onehot #(
    parameter int SEL_W = 4
) (
    input  logic [SEL_W-1:0]      i_sel,
    output logic [(2**SEL_W)-1:0] o_onehot
);

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        o_onehot = '0;
        for (int i = 0; i < 2 ** SEL_W; i++) begin
            o_onehot[i] = (i_sel == SEL_W'(i));
        end
    end

endmodule

// File: rtl/regfile_wen_sequencer.sv
// Registered write-enable decoder with a clear sequencer that sweeps a
// one-hot strobe across every register, on request or right after reset.
module regfile_wen_sequencer
    import cpu_decode_pkg::*;
#(
    parameter int SEL_W          = 4,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    regfile_wen_sequencer_if.slave bus
);

    localparam int     OUT_W       = 2 ** SEL_W;
    localparam state_t RESET_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

    state_t             r_state;
    state_t             w_next_state;
    logic [SEL_W-1:0]   r_count;
    logic [SEL_W-1:0]   w_count_next;
    logic [OUT_W-1:0]   r_dec_out;
    logic [OUT_W-1:0]   w_dec_next;
    logic [SEL_W-1:0]   r_clr_sel;
    logic [SEL_W-1:0]   w_clr_sel_next;
    logic               r_done;
    logic               w_done_next;
    logic               r_err;
    logic               w_err_next;
    logic [SEL_W-1:0]   w_dec_sel;
    logic [OUT_W-1:0]   w_onehot;

    // One shared decoder: the sweep index takes priority over the write select.
    assign w_dec_sel = (r_state == ST_CLEAR) ? r_count : bus.wr_sel;

    decoder_n_to_onehot #(
        .SEL_W (SEL_W)
    ) u_decoder (
        .i_sel    (w_dec_sel),
        .o_onehot (w_onehot)
    );

    always_comb begin
        w_next_state   = r_state;
        w_count_next   = r_count;
        w_dec_next     = '0;
        w_clr_sel_next = r_clr_sel;
        w_done_next    = 1'b0;
        w_err_next     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.clr_req) begin
                    w_next_state = ST_CLEAR;
                    w_count_next = '0;
                    w_err_next   = bus.wr_en;
                end else if (bus.wr_en) begin
                    w_dec_next = w_onehot;
                end
            end
            ST_CLEAR: begin
                w_dec_next     = w_onehot;
                w_clr_sel_next = r_count;
                w_count_next   = r_count + SEL_W'(1);
                w_err_next     = bus.wr_en;
                if (r_count == SEL_W'(OUT_W - 1)) begin
                    w_next_state = ST_IDLE;
                    w_done_next  = 1'b1;
                end
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= RESET_STATE;
            r_count   <= '0;
            r_dec_out <= '0;
            r_clr_sel <= '0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_count   <= w_count_next;
            r_dec_out <= w_dec_next;
            r_clr_sel <= w_clr_sel_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    assign bus.dec_out = r_dec_out;
    assign bus.clr_sel = r_clr_sel;
    assign bus.busy    = (r_state == ST_CLEAR);
    assign bus.done    = r_done;
    assign bus.err     = r_err;

endmodule

// File: tb/tb_regfile_wen_sequencer.sv
// Bench for regfile_wen_sequencer: a 4-bit auto-clearing instance against a
// queue-of-pending-strobes model, plus a 2-bit instance that comes up idle.
module tb_regfile_wen_sequencer;

    logic clk;
    logic rst_a;
    logic rst_b;
    int   n_assert;
    int   n_fail;

    regfile_wen_sequencer_if #(.SEL_W(4)) if_a ();
    regfile_wen_sequencer_if #(.SEL_W(2)) if_b ();

    regfile_wen_sequencer #(
        .SEL_W          (4),
        .CLEAR_ON_RESET (1'b1)
    ) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.slave)
    );

    regfile_wen_sequencer #(
        .SEL_W          (2),
        .CLEAR_ON_RESET (1'b0)
    ) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: clear strobes still owed, in issue order; busy while any remain.
    int          pend[$];
    logic [15:0] m_dec;
    logic [3:0]  m_sel;
    logic        m_done;
    logic        m_err;

    task automatic model_reset_a();
        pend.delete();
        for (int i = 0; i < 16; i++) pend.push_back(i);
        m_dec  = '0;
        m_sel  = '0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endtask

    task automatic model_edge_a(input logic we, input logic [3:0] sel, input logic clr);
        int idx;
        m_done = 1'b0;
        m_err  = 1'b0;
        if (pend.size() != 0) begin
            idx    = pend.pop_front();
            m_dec  = 16'(1) << idx;
            m_sel  = 4'(idx);
            m_done = (pend.size() == 0);
            m_err  = we;
        end else if (clr) begin
            for (int i = 0; i < 16; i++) pend.push_back(i);
            m_dec = '0;
            m_err = we;
        end else begin
            m_dec = we ? (16'(1) << sel) : 16'h0000;
        end
    endtask

    function automatic logic [22:0] exp_a();
        return {m_dec, m_sel, (pend.size() != 0), m_done, m_err};
    endfunction

    function automatic logic [22:0] got_a();
        return {if_a.dec_out, if_a.clr_sel, if_a.busy, if_a.done, if_a.err};
    endfunction

    // Drive at the falling edge, let one rising edge pass, return at the next falling edge.
    task automatic step_a(input logic we, input logic [3:0] sel, input logic clr);
        if_a.wr_en   = we;
        if_a.wr_sel  = sel;
        if_a.clr_req = clr;
        @(posedge clk);
        model_edge_a(we, sel, clr);
        @(negedge clk);
    endtask

    task automatic step_b(input logic we, input logic [1:0] sel, input logic clr);
        if_b.wr_en   = we;
        if_b.wr_sel  = sel;
        if_b.clr_req = clr;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset_a();
        #3;
        n_assert++;
        if (got_a() !== exp_a()) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h", got_a(), exp_a());
        end
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 4'd0, 1'b0);
            n_assert++;
            if (got_a() !== exp_a()) begin
                n_fail++;
                $display("FAIL power_on_sweep[%0d]: got %h expected %h", i, got_a(), exp_a());
            end
        end
        n_assert++;
        if ({if_a.dec_out, if_a.done, if_a.busy} !== {16'h8000, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL sweep_last: got dec=%h done=%b busy=%b expected dec=8000 done=1 busy=0",
                     if_a.dec_out, if_a.done, if_a.busy);
        end
        step_a(1'b0, 4'd0, 1'b0);
        n_assert++;
        if (got_a() !== exp_a()) begin
            n_fail++;
            $display("FAIL post_sweep_idle: got %h expected %h", got_a(), exp_a());
        end
    endtask

    task automatic test_writes();
        logic [3:0]  sels [3];
        logic [15:0] want [3];
        sels = '{4'd3, 4'd0, 4'd15};
        want = '{16'h0008, 16'h0001, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            step_a(1'b1, sels[i], 1'b0);
            n_assert++;
            if (if_a.dec_out !== want[i] || got_a() !== exp_a()) begin
                n_fail++;
                $display("FAIL write_strobe[%0d]: got %h expected dec %h / %h",
                         i, got_a(), want[i], exp_a());
            end
        end
        step_a(1'b0, 4'd0, 1'b0);
        n_assert++;
        if (if_a.dec_out !== 16'h0000) begin
            n_fail++;
            $display("FAIL write_release: got %h expected 0000", if_a.dec_out);
        end
    endtask

    task automatic test_clr_with_wr();
        step_a(1'b1, 4'd5, 1'b1);
        n_assert++;
        if ({if_a.err, if_a.dec_out, if_a.busy} !== {1'b1, 16'h0000, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_drops_write: got err=%b dec=%h busy=%b expected err=1 dec=0000 busy=1",
                     if_a.err, if_a.dec_out, if_a.busy);
        end
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 4'd0, 1'b0);
            n_assert++;
            if (got_a() !== exp_a() || if_a.dec_out === 16'h0020 && i != 5) begin
                n_fail++;
                $display("FAIL clr_sweep[%0d]: got %h expected %h", i, got_a(), exp_a());
            end
        end
    endtask

    task automatic test_wr_during_sweep();
        int guard;
        step_a(1'b0, 4'd0, 1'b1);
        guard = 0;
        while (pend.size() != 0 && guard < 40) begin
            step_a(pend[0] == 7, 4'($urandom_range(0, 15)), 1'b0);
            guard++;
            n_assert++;
            if (got_a() !== exp_a()) begin
                n_fail++;
                $display("FAIL busy_write[%0d]: got %h expected %h", guard, got_a(), exp_a());
            end
        end
        n_assert++;
        if (guard != 16) begin
            n_fail++;
            $display("FAIL busy_write_len: got %0d expected 16", guard);
        end
        step_a(1'b1, 4'd2, 1'b0);
        n_assert++;
        if (if_a.dec_out !== 16'h0004 || got_a() !== exp_a()) begin
            n_fail++;
            $display("FAIL done_cycle_write: got %h expected dec 0004 / %h", got_a(), exp_a());
        end
        step_a(1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_reset_mid_sweep();
        step_a(1'b0, 4'd0, 1'b1);
        for (int i = 0; i < 10; i++) step_a(1'b0, 4'd0, 1'b0);
        n_assert++;
        if (if_a.dec_out !== 16'h0200) begin
            n_fail++;
            $display("FAIL pre_reset_index: got %h expected 0200", if_a.dec_out);
        end
        #2;
        rst_a = 1'b1;
        model_reset_a();
        #1;
        n_assert++;
        if (got_a() !== exp_a()) begin
            n_fail++;
            $display("FAIL async_reset: got %h expected %h", got_a(), exp_a());
        end
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            step_a(1'b0, 4'd0, 1'b0);
            n_assert++;
            if (got_a() !== exp_a() || (i == 0 && if_a.dec_out !== 16'h0001)) begin
                n_fail++;
                $display("FAIL restart_sweep[%0d]: got %h expected %h", i, got_a(), exp_a());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            step_a(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), ($urandom_range(0, 19) == 0));
            n_assert++;
            if (got_a() !== exp_a() || !$onehot0(if_a.dec_out)) begin
                n_fail++;
                $display("FAIL random[%0d]: got %h expected %h", i, got_a(), exp_a());
            end
        end
    endtask

    task automatic test_no_auto_clear();
        logic [3:0] want_dec [4];
        want_dec = '{4'h1, 4'h2, 4'h4, 4'h8};
        n_assert++;
        if ({if_b.dec_out, if_b.busy, if_b.done, if_b.err} !== 7'b0) begin
            n_fail++;
            $display("FAIL b_reset: got dec=%h busy=%b expected dec=0 busy=0", if_b.dec_out, if_b.busy);
        end
        rst_b = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step_b(1'b0, 2'd0, 1'b0);
            n_assert++;
            if ({if_b.dec_out, if_b.busy} !== 5'b0) begin
                n_fail++;
                $display("FAIL b_idle[%0d]: got dec=%h busy=%b expected 0/0", i, if_b.dec_out, if_b.busy);
            end
        end
        step_b(1'b0, 2'd0, 1'b1);
        n_assert++;
        if ({if_b.dec_out, if_b.busy, if_b.err} !== {4'h0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL b_enter_clear: got dec=%h busy=%b err=%b expected 0/1/0",
                     if_b.dec_out, if_b.busy, if_b.err);
        end
        for (int i = 0; i < 4; i++) begin
            step_b(1'b0, 2'd0, 1'b0);
            n_assert++;
            if ({if_b.dec_out, if_b.clr_sel, if_b.done, if_b.busy} !==
                {want_dec[i], 2'(i), (i == 3), (i != 3)}) begin
                n_fail++;
                $display("FAIL b_sweep[%0d]: got dec=%h sel=%0d done=%b busy=%b expected dec=%h sel=%0d",
                         i, if_b.dec_out, if_b.clr_sel, if_b.done, if_b.busy, want_dec[i], i);
            end
        end
        step_b(1'b0, 2'd0, 1'b0);
        n_assert++;
        if ({if_b.dec_out, if_b.busy, if_b.done} !== 6'b0) begin
            n_fail++;
            $display("FAIL b_after: got dec=%h busy=%b done=%b expected 0/0/0",
                     if_b.dec_out, if_b.busy, if_b.done);
        end
    endtask

    initial begin
        n_assert     = 0;
        n_fail       = 0;
        rst_a        = 1'b1;
        rst_b        = 1'b1;
        if_a.wr_en   = 1'b0;
        if_a.wr_sel  = '0;
        if_a.clr_req = 1'b0;
        if_b.wr_en   = 1'b0;
        if_b.wr_sel  = '0;
        if_b.clr_req = 1'b0;

        test_reset();
        test_writes();
        test_clr_with_wr();
        test_wr_during_sweep();
        test_reset_mid_sweep();
        test_random();
        test_no_auto_clear();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
